rvv_lane_sequencer: RTL and testbench
=====================================

RVV_LANE_SEQUENCER -- requirements
Module: rvv_lane_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 10'd128, vector register width in bits.
REQ-002 SHALL have parameter LANE_WIDTH, default 3'b011, lane width = 2^LANE_WIDTH bits (8/16/32/64).
REQ-003 Ports: clk  in  1  sole clock, rising edge.
REQ-004 Ports: resetn  in  1  reset, asynchronous, active-low.
REQ-005 Ports: start  in  1  one-cycle request to execute one vector ALU op.
REQ-006 Ports: vsew  in  3  element width code, SEW = 8<<vsew, sampled at start.
REQ-007 Ports: vl  in  8  requested element count, sampled at start.
REQ-008 Ports: vd_init  in  VLEN  prior destination contents, sampled at start.
REQ-009 Ports: alu_vd  in  64  lane result from ALU, low 2^LANE_WIDTH bits meaningful.
REQ-010 Ports: alu_index  in  10  bit position of alu_vd inside destination.
REQ-011 Ports: alu_valid  in  1  ALU opcode-supported flag.
REQ-012 Ports: run  out  1  ALU enable.
REQ-013 Ports: byte_i  out  10  element index driven to ALU.
REQ-014 Ports: in_reg_offset  out  4  lane chunk index within current element.
REQ-015 Ports: busy  out  1  high in RUN and DONE.
REQ-016 Ports: done  out  1  one-cycle completion pulse.
REQ-017 Ports: err  out  1  valid with done; op rejected.
REQ-018 Ports: vd_out  out  VLEN  assembled destination register.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-020 In IDLE, start=1 SHALL latch vsew, vd_init into vd_out, and EL = min(vl, VLEN>>(vsew+3)); next state RUN, or DONE if EL=0, vsew>3, or alu_valid=0 (sampled same cycle).
REQ-021 Chunks per element CPE SHALL be 1 if vsew+3 <= LANE_WIDTH, else 2^(vsew+3-LANE_WIDTH).
REQ-022 In RUN, run SHALL be 1; in IDLE and DONE run, byte_i, in_reg_offset SHALL be 0.
REQ-023 RUN SHALL iterate in_reg_offset 0..CPE-1 (inner) then byte_i 0..EL-1 (outer), one chunk per cycle, total EL*CPE cycles.
REQ-024 Each RUN cycle SHALL write W = min(SEW, 2^LANE_WIDTH) low bits of alu_vd into vd_out[alu_index +: W] on the rising edge; bits outside are unchanged (tail-undisturbed).
REQ-025 Writes with alu_index+W > VLEN SHALL be dropped.
REQ-026 After the last chunk (byte_i=EL-1, in_reg_offset=CPE-1), next state SHALL be DONE.
REQ-027 In DONE, done=1; err=1 iff rejected (vsew>3 or alu_valid=0), else 0; busy=1.
REQ-028 Rejected or EL=0 ops SHALL leave vd_out = vd_init.
REQ-029 start while busy SHALL be ignored; no queuing.
REQ-030 vd_out SHALL hold its value in IDLE until next accepted start.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, vd_out=0, run=0, byte_i=0, in_reg_offset=0, busy=0, done=0, err=0.
REQ-032 Reset asserted mid-RUN SHALL abort with no done pulse; first start after release is handled normally.

Verification
REQ-033 LANE_WIDTH=3, vsew=0, vl=4, alu_vd=0xA5 -> 4 RUN cycles byte_i 0..3, in_reg_offset=0, done next cycle, vd_out[31:0]=0xA5A5A5A5, vd_out[127:32]=vd_init[127:32].
REQ-034 vsew=2, vl=1 -> in_reg_offset 0,1,2,3 with byte_i=0, 4 RUN cycles, then done.
REQ-035 vl=0 -> done one cycle after start, run never asserted, err=0, vd_out=vd_init.
REQ-036 vsew=0, vl=20 -> EL capped at 16, exactly 16 RUN cycles.
REQ-037 alu_valid=0 or vsew=3'b100 at start -> done and err=1 next cycle, vd_out=vd_init.
REQ-038 resetn pulsed low at RUN cycle 2 -> immediate IDLE, vd_out=0, no done; start afterward completes normally.

Source files
------------

// File: rtl/rvv_lane_sequencer_if.sv
// Request/ALU/result bundle between an issuing stage and the lane sequencer.
// master drives the request and ALU lane results; slave is the sequencer.
interface rvv_lane_sequencer_if #(
    parameter logic [9:0] VLEN = 10'd128
);
    logic            start;
    logic [2:0]      vsew;
    logic [7:0]      vl;
    logic [VLEN-1:0] vd_init;
    logic [63:0]     alu_vd;
    logic [9:0]      alu_index;
    logic            alu_valid;
    logic            run;
    logic [9:0]      byte_i;
    logic [3:0]      in_reg_offset;
    logic            busy;
    logic            done;
    logic            err;
    logic [VLEN-1:0] vd_out;

    modport master (
        output start, vsew, vl, vd_init, alu_vd, alu_index, alu_valid,
        input  run, byte_i, in_reg_offset, busy, done, err, vd_out
    );

    modport slave (
        input  start, vsew, vl, vd_init, alu_vd, alu_index, alu_valid,
        output run, byte_i, in_reg_offset, busy, done, err, vd_out
    );
endinterface

// File: rtl/rvv_lane_sequencer.sv
// Sequences one vector ALU op lane-chunk by lane-chunk, assembling vd_out.
// Latency: EL*CPE RUN cycles plus one DONE cycle; start is ignored while busy.
module rvv_lane_sequencer #(
    parameter logic [9:0] VLEN       = 10'd128,
    parameter logic [2:0] LANE_WIDTH = 3'b011
) (
    input logic                 clk,
    input logic                 resetn,
    rvv_lane_sequencer_if.slave bus
);
    localparam int VW        = int'(VLEN);
    localparam int LW        = int'(LANE_WIDTH);
    localparam int LANE_BITS = 1 << LW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sew_q;
    logic [9:0]    el_q;
    logic [9:0]    byte_q;
    logic [3:0]    off_q;
    logic          err_q;
    logic [VW-1:0] vd_q;

    logic [9:0]    cap;
    logic [9:0]    el_start;
    logic          reject;
    int            sh;
    int            w_bits;
    logic [3:0]    last_off;
    logic [63:0]   lane_mask;
    logic          in_range;
    logic [VW-1:0] wmask;
    logic [VW-1:0] wdat;
    logic          last_chunk;

    // Request decode uses the live inputs; element geometry uses the latched SEW.
    always_comb begin
        cap      = 10'(VW >> (int'(bus.vsew) + 3));
        el_start = ({2'b00, bus.vl} < cap) ? {2'b00, bus.vl} : cap;
        reject   = (bus.vsew > 3'd3) || !bus.alu_valid;

        sh        = int'(sew_q) + 3;
        w_bits    = (sh <= LW) ? (1 << sh) : LANE_BITS;
        last_off  = (sh <= LW) ? 4'd0 : 4'((1 << (sh - LW)) - 1);
        lane_mask = (w_bits >= 64) ? '1 : ((64'd1 << w_bits) - 64'd1);
        in_range  = (int'(bus.alu_index) + w_bits) <= VW;
        wmask     = VW'(lane_mask) << bus.alu_index;
        wdat      = VW'(bus.alu_vd & lane_mask) << bus.alu_index;

        last_chunk = (off_q == last_off) && (byte_q == el_q - 10'd1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = (reject || el_start == 10'd0) ? DONE : RUN;
            RUN:  if (last_chunk) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sew_q  <= '0;
            el_q   <= '0;
            byte_q <= '0;
            off_q  <= '0;
            err_q  <= 1'b0;
            vd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sew_q  <= bus.vsew;
                        el_q   <= el_start;
                        err_q  <= reject;
                        vd_q   <= bus.vd_init;
                        byte_q <= '0;
                        off_q  <= '0;
                    end
                end
                RUN: begin
                    // Out-of-range lane writes are dropped rather than truncated.
                    if (in_range) vd_q <= (vd_q & ~wmask) | wdat;
                    if (off_q == last_off) begin
                        off_q  <= '0;
                        byte_q <= byte_q + 10'd1;
                    end else begin
                        off_q  <= off_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.run           = (state_q == RUN);
    assign bus.byte_i        = (state_q == RUN) ? byte_q : 10'd0;
    assign bus.in_reg_offset = (state_q == RUN) ? off_q : 4'd0;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.err           = (state_q == DONE) && err_q;
    assign bus.vd_out        = vd_q;
endmodule

// File: tb/tb_rvv_lane_sequencer.sv
// Directed table-driven bench for rvv_lane_sequencer (VLEN=128, 8-bit lanes).
module tb_rvv_lane_sequencer;
    localparam logic [127:0] INIT = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

    typedef struct {
        logic [2:0]   vsew;
        logic [7:0]   vl;
        logic         valid;
        logic [63:0]  alu;
        logic [9:0]   bias;
        int           sew;
        int           w;
        int           cpe;
        int           cycles;
        logic         err;
        logic [127:0] vd;
    } vec_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    vec_t vecs [10];

    rvv_lane_sequencer_if #(.VLEN(10'd128)) bus ();

    rvv_lane_sequencer #(.VLEN(10'd128), .LANE_WIDTH(3'b011)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input int i);
        vec_t v;
        int   k;
        v = vecs[i];
        @(negedge clk);
        bus.vsew      = v.vsew;
        bus.vl        = v.vl;
        bus.alu_valid = v.valid;
        bus.alu_vd    = v.alu;
        bus.vd_init   = INIT;
        bus.alu_index = 10'd0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        for (int g = 0; g < 200 && !bus.done; g++) begin
            chk("run_high", 128'(bus.run), 128'(1));
            chk("byte_i", 128'(bus.byte_i), 128'(k / v.cpe));
            chk("in_reg_offset", 128'(bus.in_reg_offset), 128'(k % v.cpe));
            bus.alu_index = 10'((k / v.cpe) * v.sew + (k % v.cpe) * v.w + int'(v.bias));
            bus.start     = (k == 1 && v.cycles > 2);
            @(negedge clk);
            bus.start = 1'b0;
            k++;
        end
        chk("done_seen", 128'(bus.done), 128'(1));
        chk("run_cycles", 128'(k), 128'(v.cycles));
        chk("err", 128'(bus.err), 128'(v.err));
        chk("busy_in_done", 128'(bus.busy), 128'(1));
        chk("run_in_done", 128'(bus.run), 128'(0));
        chk("vd_out", bus.vd_out, v.vd);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_one_cycle", 128'(bus.done), 128'(0));
        chk("busy_idle", 128'(bus.busy), 128'(0));
        repeat (2) @(negedge clk);
        chk("vd_hold", bus.vd_out, v.vd);
    endtask

    initial begin
        int seen;
        checks   = 0;
        failures = 0;
        //          vsew  vl     vld   alu                     bias    sew w cpe cyc err  vd
        vecs[0] = '{3'd0, 8'd4,  1'b1, 64'hA5,                 10'd0,   8, 8, 1, 4,  1'b0, 128'hFFEEDDCC_BBAA9988_77665544_A5A5A5A5};
        vecs[1] = '{3'd2, 8'd1,  1'b1, 64'h3C,                 10'd0,  32, 8, 4, 4,  1'b0, 128'hFFEEDDCC_BBAA9988_77665544_3C3C3C3C};
        vecs[2] = '{3'd1, 8'd0,  1'b1, 64'h55,                 10'd0,  16, 8, 2, 0,  1'b0, INIT};
        vecs[3] = '{3'd0, 8'd20, 1'b1, 64'h5A,                 10'd0,   8, 8, 1, 16, 1'b0, {16{8'h5A}}};
        vecs[4] = '{3'd0, 8'd4,  1'b0, 64'hA5,                 10'd0,   8, 8, 1, 0,  1'b1, INIT};
        vecs[5] = '{3'd4, 8'd4,  1'b1, 64'hA5,                 10'd0,   8, 8, 1, 0,  1'b1, INIT};
        vecs[6] = '{3'd1, 8'd3,  1'b1, 64'hDEADBEEF_0000000F,  10'd0,  16, 8, 2, 6,  1'b0, 128'hFFEEDDCC_BBAA9988_77660F0F_0F0F0F0F};
        vecs[7] = '{3'd3, 8'd2,  1'b1, 64'hC3,                 10'd0,  64, 8, 8, 16, 1'b0, {16{8'hC3}}};
        vecs[8] = '{3'd3, 8'd5,  1'b1, 64'h81,                 10'd0,  64, 8, 8, 16, 1'b0, {16{8'h81}}};
        vecs[9] = '{3'd0, 8'd2,  1'b1, 64'h77,                 10'd120, 8, 8, 1, 2,  1'b0, 128'h77EEDDCC_BBAA9988_77665544_33221100};

        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.vsew      = 3'd0;
        bus.vl        = 8'd0;
        bus.vd_init   = '0;
        bus.alu_vd    = '0;
        bus.alu_index = '0;
        bus.alu_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_run", 128'(bus.run), 128'(0));
        chk("rst_byte_i", 128'(bus.byte_i), 128'(0));
        chk("rst_offset", 128'(bus.in_reg_offset), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        chk("rst_vd_out", bus.vd_out, 128'(0));

        for (int i = 0; i < 10; i++) run_op(i);

        // Reset asserted in the middle of a long op.
        @(negedge clk);
        bus.vsew      = 3'd0;
        bus.vl        = 8'd8;
        bus.alu_valid = 1'b1;
        bus.alu_vd    = 64'h11;
        bus.vd_init   = INIT;
        bus.alu_index = 10'd0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.alu_index = 10'(c * 8);
            @(negedge clk);
        end
        chk("mid_run_before_rst", 128'(bus.run), 128'(1));
        #2 resetn = 1'b0;
        #1;
        chk("arst_run", 128'(bus.run), 128'(0));
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_byte_i", 128'(bus.byte_i), 128'(0));
        chk("arst_vd_out", bus.vd_out, 128'(0));
        chk("arst_done", 128'(bus.done), 128'(0));
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("no_done_after_rst", 128'(seen), 128'(0));
        run_op(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
